prng_checker: RTL and testbench
===============================

# prng_checker

Serial bit-stream checker for the 32-bit Fibonacci LFSR generator (taps B89ADA1C). It sits at the receive end of a test link. It self-seeds from the first 32 received bits, then free-runs its own copy of the LFSR and compares each received bit against the prediction. It counts bit errors and drops lock and re-seeds when the error density exceeds a threshold.

## Interface
- ERR_WIDTH, 16: width of saturating error counter.
- CNT_WIDTH, 32: width of saturating checked-bit counter.
- WINDOW, 64: error-density window length in checked bits (power of 2, ≥ LOSS_THRESH).
- LOSS_THRESH, 8: errors within one window that force loss of lock (≥1).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ce  in  1  din valid this cycle; when low, all state holds and pulses are 0.
- clr  in  1  synchronous clear of err_count and bit_count; lock state is unaffected.
- din  in  1  received bit, equal to the generator's feedback bit for that step.
- locked  out  1  checker is in CHECK state.
- err  out  1  one-cycle pulse: the bit checked last cycle mismatched.
- sync_loss  out  1  one-cycle pulse: lock dropped last cycle.
- err_count  out  ERR_WIDTH  saturating count of mismatches while locked.
- bit_count  out  CNT_WIDTH  saturating count of bits checked while locked.

## Operation
- f(s) = s[31]^s[29]^s[28]^s[27]^s[23]^s[20]^s[19]^s[17]^s[15]^s[14]^s[12]^s[11]^s[9]^s[4]^s[3]^s[2]. These are the generator's taps.
- Registers:
  - s[31:0] is the shadow LFSR.
  - load_cnt[4:0].
  - win_cnt is log2(WINDOW) bits.
  - win_err is wide enough to hold LOSS_THRESH.
  - state ∈ {LOAD, CHECK}.
- LOAD, on ce:
  - s ← {s[30:0], din}, load_cnt ← load_cnt+1.
  - When load_cnt==31, the new s is evaluated. If it is all-zero (the LFSR lock-up state), stay in LOAD with load_cnt←0. Otherwise go to CHECK with load_cnt←0, win_cnt←0, win_err←0.
  - No err or count activity in LOAD.
- CHECK, on ce:
  - exp=f(s), mis=din^exp.
  - s ← {s[30:0], exp}. The prediction is shifted in, never din, so one flipped bit yields exactly one error.
  - err ← mis.
  - bit_count +1, saturating at all-ones.
  - If mis, err_count +1, saturating at all-ones.
  - If win_err+mis == LOSS_THRESH: state←LOAD, sync_loss←1, load_cnt←0, s unchanged (it is fully overwritten by the next 32 bits).
  - Otherwise, if win_cnt==WINDOW-1: win_cnt←0, win_err←0. Else win_cnt+1, win_err+mis.
  - The window is fixed (tumbling) and aligned to lock acquisition.
- clr has priority over increment in the same cycle: counters become 0. It works in either state and regardless of ce.
- err and sync_loss are 0 in any cycle not following a qualifying ce.
- err_count and bit_count hold across loss and re-lock; only rst or clr clears them.

## Timing
- Reset values:
  - locked=0, err=0, sync_loss=0, err_count=0, bit_count=0.
  - s=0, state=LOAD, load_cnt=0, win_cnt=0, win_err=0.
- After rst, a clean stream locks on the 32nd ce. locked goes high in the cycle after that edge, and s then equals the generator's q.
- The first checked bit is the 33rd received bit.
- err, the counters and sync_loss all update on the edge that samples the offending din. They are visible the following cycle (latency 1).
- On loss, locked falls in the same cycle sync_loss is high. The bit that triggered the loss is not reloaded.
- rst asserted at any time (mid-load or mid-check) clears everything immediately. Nothing is carried over.
- ce gaps of any length are transparent. Results depend only on the sequence of ce-qualified bits.

## Test plan
- Reset/idle: assert rst with ce=0 held for 10 cycles → all outputs 0, locked=0.
- Clean lock: drive a generator seeded 0xAAAAAAAA, 1000 bits, ce held high.
  - locked rises after bit 32.
  - err never pulses.
  - err_count=0, bit_count=968.
  - Repeat with random ce gaps → identical final counts.
- Single error: as in clean lock, but invert bit 100.
  - Exactly one err pulse, one cycle after bit 100 is sampled.
  - err_count=1, locked stays 1, no further errors.
- Loss and relock: invert bits 200–207 while locked.
  - err_count=8.
  - sync_loss pulses once, on bit 207.
  - locked=0 for the next 32 bits, then re-locks (s equals the generator state after bit 239).
  - No errors afterward.
  - Variant: 7 errors spread so each window holds ≤7 → no loss.
- Lock-up: drive 96 zero bits → locked never asserts, err never pulses. Then drive a generator stream → locks after 32 bits.
- Saturation/clr: ERR_WIDTH=4, 20 isolated errors spaced 100 bits apart.
  - err_count stops at 15.
  - Assert clr coincident with an error → err_count=0 next cycle, and the increment is lost.

Source files
------------

// File: rtl/prng_checker.sv
// prng_checker: receive-side checker for the 32-bit Fibonacci LFSR stream
// (taps B89ADA1C). Self-seeds from 32 received bits, then predicts every
// following bit, counts mismatches and drops lock when too many errors land
// inside one tumbling window of checked bits.
module prng_checker #(
  parameter int ERR_WIDTH   = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 clr,
  input  logic                 din,
  output logic                 locked,
  output logic                 err,
  output logic                 sync_loss,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] bit_count
);

  localparam logic [31:0] TAPS = 32'hB89A_DA1C;
  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WE_W = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [WE_W:0]   THRESH   = (WE_W + 1)'(LOSS_THRESH);

  typedef enum logic {
    LOAD  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [31:0]     s, s_next;
  logic [4:0]      load_cnt, load_cnt_next;
  logic [WC_W-1:0] win_cnt, win_cnt_next;
  logic [WE_W-1:0] win_err, win_err_next;
  logic            err_next, loss_next;
  logic            count_bit, count_err;
  logic            exp_bit, mis;
  logic [WE_W:0]   win_sum;

  // Prediction of the current bit and the error tally it would produce.
  always_comb begin
    exp_bit = ^(s & TAPS);
    mis     = din ^ exp_bit;
    win_sum = {1'b0, win_err} + {{WE_W{1'b0}}, mis};
  end

  // State register for the LOAD/CHECK machine.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state and datapath update decisions for one ce-qualified bit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next    = state;
    s_next        = s;
    load_cnt_next = load_cnt;
    win_cnt_next  = win_cnt;
    win_err_next  = win_err;
    err_next      = 1'b0;
    loss_next     = 1'b0;
    count_bit     = 1'b0;
    count_err     = 1'b0;
    if (ce) begin
      unique case (state)
        LOAD: begin
          s_next        = {s[30:0], din};
          load_cnt_next = load_cnt + 5'd1;
          if (load_cnt == 5'd31) begin
            load_cnt_next = 5'd0;
            // An all-zero seed is the LFSR lock-up state: keep loading.
            if (s_next != 32'd0) begin
              state_next   = CHECK;
              win_cnt_next = '0;
              win_err_next = '0;
            end
          end
        end
        CHECK: begin
          // Shift in the prediction, not din, so a flipped bit costs one error.
          s_next    = {s[30:0], exp_bit};
          err_next  = mis;
          count_bit = 1'b1;
          count_err = mis;
          if (win_sum == THRESH) begin
            state_next    = LOAD;
            loss_next     = 1'b1;
            load_cnt_next = 5'd0;
            s_next        = s;
          end else if (win_cnt == WIN_LAST) begin
            win_cnt_next = '0;
            win_err_next = '0;
          end else begin
            win_cnt_next = win_cnt + 1'b1;
            win_err_next = win_sum[WE_W-1:0];
          end
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // Shadow LFSR, load/window bookkeeping and the one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      load_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err       <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      s         <= s_next;
      load_cnt  <= load_cnt_next;
      win_cnt   <= win_cnt_next;
      win_err   <= win_err_next;
      err       <= err_next;
      sync_loss <= loss_next;
    end
  end

  // Saturating statistics; clr wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      bit_count <= '0;
    end else if (clr) begin
      err_count <= '0;
      bit_count <= '0;
    end else begin
      if (count_bit && !(&bit_count)) bit_count <= bit_count + 1'b1;
      if (count_err && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end

  assign locked = (state == CHECK);

endmodule

// File: tb/tb_prng_checker.sv
// tb_prng_checker: randomized scoreboard bench for prng_checker. A driver
// feeds generator bit streams (with planted errors, ce gaps and clr pulses)
// and pushes the reference model's expected outputs; a monitor pops and
// compares one entry after every clock edge that saw ce or clr.
module tb_prng_checker;

  localparam int EW   = 4;
  localparam int CW   = 12;
  localparam int WIN  = 64;
  localparam int THR  = 8;
  localparam int EMAX = (1 << EW) - 1;
  localparam int BMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce  = 1'b0;
  logic          clr = 1'b0;
  logic          din = 1'b0;
  logic          locked, err, sync_loss;
  logic [EW-1:0] err_count;
  logic [CW-1:0] bit_count;

  prng_checker #(
    .ERR_WIDTH  (EW),
    .CNT_WIDTH  (CW),
    .WINDOW     (WIN),
    .LOSS_THRESH(THR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .clr      (clr),
    .din      (din),
    .locked   (locked),
    .err      (err),
    .sync_loss(sync_loss),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic err;
    logic loss;
    logic locked;
    int   errc;
    int   bitc;
  } exp_t;

  exp_t sb[$];

  int tap_idx[16] = '{31, 29, 28, 27, 23, 20, 19, 17, 15, 14, 12, 11, 9, 4, 3, 2};

  function automatic logic fb(input logic [31:0] v);
    logic p = 1'b0;
    foreach (tap_idx[k]) p ^= v[tap_idx[k]];
    return p;
  endfunction

  logic        m_locked;
  logic        m_load[$];
  logic [31:0] m_seed;
  int          m_chk, m_werr, m_errc, m_bitc;

  function automatic void model_reset();
    m_locked = 1'b0;
    m_load.delete();
    m_seed = '0;
    m_chk  = 0;
    m_werr = 0;
    m_errc = 0;
    m_bitc = 0;
  endfunction

  function automatic void model_step(input logic c_e, input logic d, input logic c_l);
    exp_t        e;
    logic [31:0] v;
    logic        p, mis;
    e.err  = 1'b0;
    e.loss = 1'b0;
    if (c_e) begin
      if (!m_locked) begin
        m_load.push_back(d);
        if (m_load.size() == 32) begin
          v = '0;
          foreach (m_load[k]) v = {v[30:0], m_load[k]};
          m_load.delete();
          if (v != 32'd0) begin
            m_locked = 1'b1;
            m_seed   = v;
            m_chk    = 0;
            m_werr   = 0;
          end
        end
      end else begin
        p      = fb(m_seed);
        mis    = d ^ p;
        m_seed = {m_seed[30:0], p};
        e.err  = mis;
        if (m_bitc < BMAX) m_bitc++;
        if (mis && m_errc < EMAX) m_errc++;
        if (m_chk % WIN == 0) m_werr = 0;
        m_werr += int'(mis);
        m_chk++;
        if (m_werr == THR) begin
          m_locked = 1'b0;
          e.loss   = 1'b1;
        end
      end
    end
    if (c_l) begin
      m_errc = 0;
      m_bitc = 0;
    end
    e.locked = m_locked;
    e.errc   = m_errc;
    e.bitc   = m_bitc;
    sb.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  int loss_seen = 0;
  int err_seen  = 0;

  initial begin
    logic c_ce, c_clr;
    exp_t e;
    forever begin
      @(posedge clk);
      c_ce  = ce;
      c_clr = clr;
      #1;
      if (err) err_seen++;
      if (sync_loss) loss_seen++;
      if (c_ce || c_clr) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("err", 64'(err), 64'(e.err));
          check("sync_loss", 64'(sync_loss), 64'(e.loss));
          check("locked", 64'(locked), 64'(e.locked));
          check("err_count", 64'(err_count), 64'(e.errc));
          check("bit_count", 64'(bit_count), 64'(e.bitc));
        end
      end else begin
        check("idle_err", 64'(err), 64'd0);
        check("idle_sync_loss", 64'(sync_loss), 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] gen;
  int          bit_no;
  bit          flip_set[int];
  bit          clr_set[int];

  task automatic idle_cycle();
    @(negedge clk);
    ce  = 1'b0;
    clr = 1'b0;
    din = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic d, input logic c, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) idle_cycle();
    @(negedge clk);
    ce  = 1'b1;
    din = d;
    clr = c;
    model_step(1'b1, d, c);
    @(posedge clk);
    #1;
    ce  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic clr_only();
    @(negedge clk);
    ce  = 1'b0;
    clr = 1'b1;
    model_step(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic start_gen(input logic [31:0] seed);
    gen    = seed;
    bit_no = 0;
    flip_set.delete();
    clr_set.delete();
  endtask

  task automatic stream(input int n, input bit gaps);
    logic b;
    for (int i = 0; i < n; i++) begin
      bit_no++;
      b   = fb(gen);
      gen = {gen[30:0], b};
      if (flip_set.exists(bit_no)) b = ~b;
      send(b, clr_set.exists(bit_no), gaps);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b0;
    clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    loss_seen = 0;
    err_seen  = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_sync_loss"}, 64'(sync_loss), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_bit_count"}, 64'(bit_count), 64'd0);
  endtask

  initial begin
    #600000;
    check("watchdog_timeout", 64'd1, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [31:0] rseed;
    model_reset();

    // Reset with ce low for 10 cycles.
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_outputs_zero("reset_idle");
    rst = 1'b0;

    // Clean lock, ce held high.
    do_reset();
    start_gen(32'hAAAA_AAAA);
    stream(1000, 1'b0);
    idle_cycle();
    check("clean_err_count", 64'(err_count), 64'd0);
    check("clean_bit_count", 64'(bit_count), 64'd968);
    check("clean_err_pulses", 64'(err_seen), 64'd0);

    // Same stream with random ce gaps.
    do_reset();
    start_gen(32'hAAAA_AAAA);
    stream(1000, 1'b1);
    idle_cycle();
    check("gaps_err_count", 64'(err_count), 64'd0);
    check("gaps_bit_count", 64'(bit_count), 64'd968);

    // Single flipped bit.
    do_reset();
    start_gen(32'hAAAA_AAAA);
    flip_set[100] = 1'b1;
    stream(1000, 1'b0);
    idle_cycle();
    check("single_err_count", 64'(err_count), 64'd1);
    check("single_err_pulses", 64'(err_seen), 64'd1);
    check("single_locked", 64'(locked), 64'd1);

    // Eight errors in one window: loss and relock.
    do_reset();
    start_gen(32'hAAAA_AAAA);
    for (int i = 200; i <= 207; i++) flip_set[i] = 1'b1;
    stream(400, 1'b0);
    idle_cycle();
    check("loss_err_count", 64'(err_count), 64'd8);
    check("loss_pulses", 64'(loss_seen), 64'd1);
    check("loss_relocked", 64'(locked), 64'd1);
    check("loss_bit_count", 64'(bit_count), 64'(400 - 32 - 32));

    // Seven errors either side of a window boundary: no loss.
    do_reset();
    start_gen(32'h1234_5678);
    for (int i = 346; i <= 359; i++) flip_set[i] = 1'b1;
    stream(500, 1'b0);
    idle_cycle();
    check("spread_err_count", 64'(err_count), 64'd14);
    check("spread_no_loss", 64'(loss_seen), 64'd0);
    check("spread_locked", 64'(locked), 64'd1);

    // Lock-up seed: zeros never lock, then a real stream does.
    do_reset();
    for (int i = 0; i < 96; i++) send(1'b0, 1'b0, 1'b0);
    idle_cycle();
    check("lockup_locked", 64'(locked), 64'd0);
    check("lockup_err_pulses", 64'(err_seen), 64'd0);
    start_gen(32'hDEAD_BEEF);
    stream(40, 1'b0);
    check("lockup_relock", 64'(locked), 64'd1);

    // Reset in the middle of checking.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #2;
    check_outputs_zero("midreset");
    @(negedge clk);
    rst = 1'b0;

    // Saturation of err_count, then clr coincident with an error.
    do_reset();
    start_gen(32'hAAAA_AAAA);
    for (int i = 100; i <= 2000; i += 100) flip_set[i] = 1'b1;
    flip_set[2050] = 1'b1;
    clr_set[2050]  = 1'b1;
    stream(2040, 1'b0);
    idle_cycle();
    check("sat_err_count", 64'(err_count), 64'(EMAX));
    stream(60, 1'b0);
    idle_cycle();
    check("clr_err_count", 64'(err_count), 64'd0);
    check("clr_bit_count", 64'(bit_count), 64'd50);
    clr_only();
    check("clr_idle_bit_count", 64'(bit_count), 64'd0);
    check("clr_keeps_lock", 64'(locked), 64'd1);
    stream(4200, 1'b0);
    idle_cycle();
    check("sat_bit_count", 64'(bit_count), 64'(BMAX));

    // Randomized: random seed, error sprinkles and bursts, gaps, clr pulses.
    do_reset();
    rseed = $urandom | 32'h1;
    start_gen(rseed);
    for (int i = 33; i <= 2500; i++)
      if ($urandom_range(0, 99) < 2) flip_set[i] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      int at = $urandom_range(100, 2300);
      for (int i = 0; i < 10; i++) flip_set[at + i] = 1'b1;
    end
    for (int i = 0; i < 5; i++) clr_set[$urandom_range(50, 2500)] = 1'b1;
    stream(2500, 1'b1);

    repeat (3) idle_cycle();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
